// File: rtl/wheel_pulse_gen_pkg.sv
// Shared definitions for the code-wheel pulse generator:
// slot/period defaults, FSM encoding and tooth length split.
package wheel_pulse_gen_pkg;

  localparam int SLOTS_DEF      = 44;
  localparam int MIN_PERIOD_DEF = 4;

  localparam logic [2:0] ST_IDLE = 3'b001;
  localparam logic [2:0] ST_LOW  = 3'b010;
  localparam logic [2:0] ST_HIGH = 3'b100;

  typedef struct packed {
    logic [31:0] low;
    logic [31:0] high;
  } tooth_len_t;

  // Zero tooth is low-quarter / high-rest so the decoder sees a wide mark
  function automatic tooth_len_t tooth_lengths(
    input logic [31:0] p,
    input logic        is_zero
  );
    tooth_len_t t;
    if (is_zero) begin
      t.low  = p >> 2;
      t.high = p - (p >> 2);
    end else begin
      t.high = p >> 1;
      t.low  = p - (p >> 1);
    end
    return t;
  endfunction

endpackage

// File: rtl/wheel_pulse_gen_phase_timer.sv
// Loadable down-counter timing one LOW/HIGH phase.
// Clear beats hold, hold beats load; done while count is 0.
module phase_timer #(
  parameter int PW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          hold,
  input  logic          load,
  input  logic [PW-1:0] load_val,
  output logic [PW-1:0] cnt,
  output logic          done
);

  logic [PW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (hold) begin
      cnt_d = cnt_q;
    end else if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt  = cnt_q;
  assign done = (cnt_q == '0);

endmodule

// File: rtl/wheel_pulse_gen.sv
// Code-wheel feedback emulator: SLOTS teeth per turn,
// tooth 0 widened as zero marker, runtime period and stall.
module wheel_pulse_gen
  import wheel_pulse_gen_pkg::*;
#(
  parameter int SLOTS      = SLOTS_DEF,
  parameter int PW         = 32,
  parameter int MIN_PERIOD = MIN_PERIOD_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          enable,
  input  logic [PW-1:0] period_in,
  input  logic          stall,
  output logic          pulse_sig,
  output logic          zero_mark,
  output logic [7:0]    slot_idx,
  output logic          rev_done,
  output logic          busy
);

  localparam logic [7:0]    LAST = 8'(SLOTS - 1);
  localparam logic [PW-1:0] PMIN = PW'(MIN_PERIOD);

  logic [2:0]    state_q, state_d;
  logic [7:0]    slot_q, slot_d;
  logic [PW-1:0] p_q, p_d;
  logic          pulse_q, pulse_d;
  logic          zero_q, zero_d;
  logic          rev_q, rev_d;

  logic [PW-1:0] p_in_c;
  logic [PW-1:0] cnt;
  logic [PW-1:0] tmr_val;
  logic          tmr_clr, tmr_hold, tmr_load, tmr_done;
  tooth_len_t    len_cur, len_nxt;

  always_comb begin
    p_in_c = (period_in < PMIN) ? PMIN : period_in;
  end

  always_comb begin
    state_d  = state_q;
    slot_d   = slot_q;
    p_d      = p_q;
    zero_d   = 1'b0;
    rev_d    = 1'b0;
    tmr_clr  = ~enable;
    tmr_hold = stall;
    tmr_load = 1'b0;
    tmr_val  = '0;
    len_cur  = tooth_lengths(32'(p_q), slot_q == 8'd0);
    len_nxt  = '0;
    if (!enable) begin
      state_d = ST_IDLE;
      slot_d  = '0;
    end else if (!stall) begin
      unique case (1'b1)
        state_q[0]: begin
          p_d      = p_in_c;
          slot_d   = '0;
          state_d  = ST_LOW;
          len_nxt  = tooth_lengths(32'(p_in_c), 1'b1);
          tmr_load = 1'b1;
          tmr_val  = PW'(len_nxt.low - 32'd1);
        end
        state_q[1]: begin
          if (tmr_done) begin
            state_d  = ST_HIGH;
            tmr_load = 1'b1;
            tmr_val  = PW'(len_cur.high - 32'd1);
            zero_d   = (slot_q == 8'd0);
          end
        end
        state_q[2]: begin
          if (tmr_done) begin
            slot_d   = (slot_q == LAST) ? 8'd0
                                        : slot_q + 8'd1;
            p_d      = p_in_c;
            state_d  = ST_LOW;
            len_nxt  = tooth_lengths(32'(p_in_c),
                                     slot_d == 8'd0);
            tmr_load = 1'b1;
            tmr_val  = PW'(len_nxt.low - 32'd1);
          end else begin
            // Count 1 now means the next cycle is the last HIGH one
            rev_d = (slot_q == LAST) && (cnt == PW'(1));
          end
        end
        default: ;
      endcase
    end
    pulse_d = state_d[2];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      slot_q  <= '0;
      p_q     <= '0;
      pulse_q <= 1'b0;
      zero_q  <= 1'b0;
      rev_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      p_q     <= p_d;
      pulse_q <= pulse_d;
      zero_q  <= zero_d;
      rev_q   <= rev_d;
    end
  end

  phase_timer #(
    .PW(PW)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (tmr_clr),
    .hold     (tmr_hold),
    .load     (tmr_load),
    .load_val (tmr_val),
    .cnt      (cnt),
    .done     (tmr_done)
  );

  assign pulse_sig = pulse_q;
  assign zero_mark = zero_q;
  assign rev_done  = rev_q;
  assign slot_idx  = slot_q;
  assign busy      = ~state_q[0];

endmodule

// File: tb/tb_wheel_pulse_gen.sv
// Bench for wheel_pulse_gen: tooth-time reference model
// checked every cycle, plus directed length measurements.
module tb_wheel_pulse_gen;
  import wheel_pulse_gen_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic [31:0] period_in;
  logic        stall;
  logic        pulse_sig;
  logic        zero_mark;
  logic [7:0]  slot_idx;
  logic        rev_done;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic        m_idle = 1'b1;
  logic [31:0] m_t    = '0;
  logic [31:0] m_slot = '0;
  logic [31:0] m_p    = 32'd4;

  wheel_pulse_gen #(
    .SLOTS(44),
    .PW(32),
    .MIN_PERIOD(4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .period_in (period_in),
    .stall     (stall),
    .pulse_sig (pulse_sig),
    .zero_mark (zero_mark),
    .slot_idx  (slot_idx),
    .rev_done  (rev_done),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d",
             tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] clampp(input logic [31:0] v);
    return (v < 32'd4) ? 32'd4 : v;
  endfunction

  // One clock: advance the tooth-time model, then compare outputs
  task automatic step();
    tooth_len_t ln;
    logic adv;
    @(posedge clk);
    cyc++;
    adv = 1'b0;
    if (!rst_n || !enable) begin
      m_idle = 1'b1;
      m_t    = '0;
      m_slot = '0;
    end else if (stall) begin
      adv = 1'b0;
    end else if (m_idle) begin
      m_idle = 1'b0;
      m_slot = '0;
      m_t    = '0;
      m_p    = clampp(period_in);
    end else begin
      adv = 1'b1;
      m_t = m_t + 1;
      if (m_t == m_p) begin
        m_t    = '0;
        m_slot = (m_slot + 1) % 44;
        m_p    = clampp(period_in);
      end
    end
    ln = tooth_lengths(m_p, m_slot == 0);
    #1;
    chk("pulse", {31'd0, pulse_sig},
        {31'd0, !m_idle && (m_t >= ln.low)});
    chk("zero", {31'd0, zero_mark},
        {31'd0, adv && m_slot == 0 && m_t == ln.low});
    chk("rev", {31'd0, rev_done},
        {31'd0, adv && m_slot == 43 && m_t == m_p - 1});
    chk("slot", {24'd0, slot_idx}, m_idle ? 32'd0 : m_slot);
    chk("busy", {31'd0, busy}, {31'd0, !m_idle});
  endtask

  task automatic measure(input logic lvl, output int n);
    n = 0;
    while (pulse_sig === lvl && n < 5000) begin
      step();
      n++;
    end
  endtask

  task automatic wait_high(input logic [7:0] s);
    int k;
    k = 0;
    while (!(slot_idx === s && pulse_sig === 1'b1) && k < 10000) begin
      step();
      k++;
    end
    chk("wait_slot", {24'd0, slot_idx}, {24'd0, s});
  endtask

  task automatic restart(input logic [31:0] per);
    enable = 1'b0;
    step();
    period_in = per;
    enable    = 1'b1;
    step();
  endtask

  initial begin
    int n;
    int k;
    int bad;
    int start;
    clk       = 1'b0;
    rst_n     = 1'b0;
    enable    = 1'b0;
    stall     = 1'b0;
    period_in = 32'd100;
    step();
    step();
    chk("rst_pulse", {31'd0, pulse_sig}, 32'd0);
    chk("rst_slot", {24'd0, slot_idx}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    rst_n = 1'b1;
    step();
    chk("idle_busy", {31'd0, busy}, 32'd0);

    enable = 1'b1;
    step();
    start = cyc;
    measure(1'b0, n); chk("nom_z_low", n, 25);
    chk("nom_zero_mark", {31'd0, zero_mark}, 32'd1);
    measure(1'b1, n); chk("nom_z_high", n, 75);
    measure(1'b0, n); chk("nom_s1_low", n, 50);
    measure(1'b1, n); chk("nom_s1_high", n, 50);
    k = 0;
    while (rev_done !== 1'b1 && k < 5000) begin
      step();
      k++;
    end
    chk("nom_rev_cycle", cyc - start, 4399);
    step();
    chk("nom_wrap_slot", {24'd0, slot_idx}, 32'd0);

    restart(32'd2);
    measure(1'b0, n); chk("clamp2_z_low", n, 1);
    measure(1'b1, n); chk("clamp2_z_high", n, 3);
    measure(1'b0, n); chk("clamp2_low", n, 2);
    measure(1'b1, n); chk("clamp2_high", n, 2);
    restart(32'd0);
    measure(1'b0, n); chk("clamp0_z_low", n, 1);
    measure(1'b1, n); chk("clamp0_z_high", n, 3);
    measure(1'b0, n); chk("clamp0_low", n, 2);

    restart(32'd100);
    wait_high(8'd5);
    repeat (25) step();
    period_in = 32'd40;
    measure(1'b1, n); chk("chg_s5_rest_high", n, 25);
    measure(1'b0, n); chk("chg_s6_low", n, 20);
    measure(1'b1, n); chk("chg_s6_high", n, 20);

    restart(32'd100);
    wait_high(8'd3);
    repeat (29) step();
    stall = 1'b1;
    bad   = 0;
    repeat (1000) begin
      step();
      if (pulse_sig !== 1'b1 || slot_idx !== 8'd3) bad++;
    end
    chk("stall_hold", bad, 0);
    stall = 1'b0;
    step();
    measure(1'b1, n); chk("stall_rest_high", n, 20);

    restart(32'd100);
    wait_high(8'd0);
    repeat (10) step();
    enable = 1'b0;
    step();
    chk("endrop_pulse", {31'd0, pulse_sig}, 32'd0);
    chk("endrop_busy", {31'd0, busy}, 32'd0);
    chk("endrop_slot", {24'd0, slot_idx}, 32'd0);
    enable = 1'b1;
    step();
    measure(1'b0, n); chk("reen_z_low", n, 25);
    measure(1'b1, n); chk("reen_z_high", n, 75);

    wait_high(8'd10);
    rst_n = 1'b0;
    step();
    chk("mrst_pulse", {31'd0, pulse_sig}, 32'd0);
    chk("mrst_zero", {31'd0, zero_mark}, 32'd0);
    chk("mrst_rev", {31'd0, rev_done}, 32'd0);
    chk("mrst_slot", {24'd0, slot_idx}, 32'd0);
    chk("mrst_busy", {31'd0, busy}, 32'd0);
    rst_n  = 1'b1;
    enable = 1'b0;
    repeat (5) step();
    chk("mrst_idle", {31'd0, busy}, 32'd0);
    enable = 1'b1;
    step();
    chk("mrst_start", {31'd0, busy}, 32'd1);

    for (int i = 0; i < 3000; i++) begin
      rst_n     = ($urandom_range(0, 99) != 0);
      enable    = ($urandom_range(0, 49) != 0);
      stall     = ($urandom_range(0, 9) == 0);
      period_in = 32'($urandom_range(0, 12));
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wheel_pulse_gen.md
Name: wheel_pulse_gen

Overview:
Code-wheel feedback emulator: the transmit end of the encoder-wheel interface that the motor position/zero decoder receives. It produces `pulse_sig` with SLOTS teeth per revolution, and tooth 0 is a widened zero marker. It drives the decoder in simulation and in FPGA self-test when no motor is fitted. Rotation speed is set by a runtime period, and a stall input emulates a blocked motor.

Parameters:
SLOTS, 44, teeth per revolution; tooth 0 is the zero marker
PW, 32, width of the period input and of the internal phase counter
MIN_PERIOD, 4, floor applied to period_in

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
enable  in  1  run the generator; 0 forces idle
period_in  in  PW  clock cycles per tooth; sampled at the start of each tooth
stall  in  1  freeze the waveform (blocked motor)
pulse_sig  out  1  emulated wheel feedback
zero_mark  out  1  1-cycle strobe on the rising edge of the zero tooth
slot_idx  out  8  index of the current tooth, 0..SLOTS-1
rev_done  out  1  1-cycle strobe on the last cycle of tooth SLOTS-1
busy  out  1  high while not in IDLE

Behaviour:
- Reset: synchronous, active-low.
  - All outputs are 0; state is IDLE.
  - Reset asserted mid-tooth aborts at once; `pulse_sig` is 0 on the next edge.
- Tooth format: LOW phase first, then HIGH phase; tooth length = P cycles.
  - P = max(period_in, MIN_PERIOD), latched on the first cycle of each LOW phase.
  - period_in changes mid-tooth take effect at the next tooth only.
- Normal tooth (slot_idx != 0): low = P - (P>>1), high = P>>1.
- Zero tooth (slot_idx == 0): low = P>>2, high = P - (P>>2).
  - This makes high exceed 1.5 × low for every P >= MIN_PERIOD.
- Phase timing: a PW-bit down-counter is loaded with the phase length minus 1; the phase ends when the count reaches 0.
- States:
  - IDLE: `pulse_sig` = 0, slot_idx = 0. On enable=1, go to LOW with slot 0 on the next cycle, latching P.
  - LOW: `pulse_sig` = 0. When the count ends, go to HIGH and load the high length.
  - HIGH: `pulse_sig` = 1. When the count ends:
    - slot_idx = SLOTS-1 wraps to 0; otherwise slot_idx increments.
    - Go to LOW and latch the new P.
- Strobes:
  - zero_mark asserts in the first HIGH cycle of slot 0.
  - rev_done asserts in the last HIGH cycle of slot SLOTS-1.
  - Both strobes are registered, aligned with `pulse_sig`, and exactly 1 cycle wide.
- Stall:
  - While stall=1, the counter, state, slot_idx and `pulse_sig` all hold, and no strobes fire.
  - On release, timing continues from the held count; the phase is not restarted.
- enable deassert (any state, including during stall): next cycle is IDLE with `pulse_sig` = 0 and slot_idx = 0.
- Re-enable always restarts at slot 0 with the zero tooth.
- Simultaneous events, in priority order: rst_n > ~enable > stall > phase end.
- Output registers:
  - `pulse_sig` is driven straight from a flop (glitch-free).
  - All outputs are registered; there is no combinational path from inputs to outputs.

Decomposition:
- Shared package holds:
  - SLOTS and MIN_PERIOD defaults.
  - The state encoding (IDLE/LOW/HIGH, one-hot).
  - A function `tooth_lengths(P, is_zero)` returning the low/high cycle counts; the bench scoreboard reuses it.
- One natural sub-module, `phase_timer`: a loadable PW-bit down-counter with hold (stall) and a done flag.
- Everything else stays in the top level.

Test Plan:
- Nominal revolution: period_in=100, enable=1 from reset.
  - Slot 0 gives low 25, high 75.
  - Slots 1..43 give low 50, high 50.
  - rev_done fires at cycle 4400 after the LOW start.
  - zero_mark fires once per revolution, at the first high cycle of slot 0.
- Clamp: period_in=2 gives normal low 2/high 2 and zero low 1/high 3; period_in=0 gives the same.
- Period change mid-tooth:
  - Start with period_in=100; change to 40 in the middle of slot 5 HIGH.
  - Slot 5 keeps 50/50; slot 6 is 20/20.
- Stall:
  - Assert stall for 1000 cycles at cycle 30 of slot 3 HIGH.
  - `pulse_sig` holds 1 throughout; after release, exactly 20 more high cycles follow.
  - slot_idx stays unchanged during the stall.
- enable drop during the zero tooth HIGH: next cycle `pulse_sig`=0, busy=0, slot_idx=0.
  - Re-enable yields a zero tooth of 25/75 first.
- Reset mid-operation: rst_n=0 for 1 cycle during slot 10 → all outputs 0 on the next edge.
  - Remains IDLE until enable is seen after reset.
